// File: rtl/clock_meas_pkg.sv
// Shared types and defaults for the slow-clock period/high-time meter.
package clock_meas_pkg;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} meas_state_t;

  localparam int DEF_COUNT_W = 26;
  localparam int DEF_TIMEOUT = 54_000_000;
  localparam int CLK_27_HZ   = 27_000_000;

endpackage

// File: rtl/clock_period_meter_sync_edge_detect.sv
// Synchronizes an asynchronous input into clk_27 and emits registered one-cycle rise/fall pulses.
// Both pulses appear SYNC_STAGES+1 cycles after the corresponding input edge.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_27,
  input  logic reset,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   rise_reg;
  logic                   fall_reg;

  always_ff @(posedge clk_27) begin
    if (reset) begin
      sync_reg[0] <= 1'b0;
    end else begin
      sync_reg[0] <= sig_in;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk_27) begin
        if (reset) begin
          sync_reg[gi] <= 1'b0;
        end else begin
          sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  // Clearing prev_reg on reset means an input already high at reset exit yields one rise pulse.
  always_ff @(posedge clk_27) begin
    if (reset) begin
      prev_reg <= 1'b0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      prev_reg <= sync_reg[SYNC_STAGES-1];
      rise_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
      fall_reg <= ~sync_reg[SYNC_STAGES-1] & prev_reg;
    end
  end

  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous input in clk_27 cycles,
// reporting each result (or a timeout abort) through a valid/ack handshake.
module clock_period_meter
  import clock_meas_pkg::*;
#(
  parameter int COUNT_W     = DEF_COUNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_27,
  input  logic               reset,
  input  logic               sig_in,
  input  logic               start,
  output logic               busy,
  output logic               meas_valid,
  input  logic               meas_ack,
  output logic [COUNT_W-1:0] period,
  output logic [COUNT_W-1:0] high_time,
  output logic               timeout
);

  localparam logic [COUNT_W-1:0] CNT_MAX      = '1;
  localparam logic [COUNT_W-1:0] TIMEOUT_LAST = COUNT_W'(TIMEOUT - 1);

  meas_state_t        state_reg;
  logic [COUNT_W-1:0] cnt_reg;
  logic [COUNT_W-1:0] period_reg;
  logic [COUNT_W-1:0] high_time_reg;
  logic               timeout_reg;
  logic               meas_valid_reg;
  logic               high_seen_reg;

  logic               rise;
  logic               fall;
  logic [COUNT_W-1:0] cnt_next;
  logic               at_limit;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk_27(clk_27),
    .reset (reset),
    .sig_in(sig_in),
    .rise  (rise),
    .fall  (fall)
  );

  assign cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
  assign at_limit = (cnt_reg == TIMEOUT_LAST);

  always_ff @(posedge clk_27) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      period_reg     <= '0;
      high_time_reg  <= '0;
      timeout_reg    <= 1'b0;
      meas_valid_reg <= 1'b0;
      high_seen_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg     <= ARM;
            cnt_reg       <= '0;
            period_reg    <= '0;
            high_time_reg <= '0;
            timeout_reg   <= 1'b0;
          end
        end
        ARM: begin
          if (rise) begin
            state_reg     <= MEASURE;
            cnt_reg       <= COUNT_W'(1);
            high_seen_reg <= 1'b0;
          end else if (at_limit) begin
            state_reg      <= DONE;
            timeout_reg    <= 1'b1;
            meas_valid_reg <= 1'b1;
            period_reg     <= '0;
            high_time_reg  <= '0;
          end else begin
            cnt_reg <= cnt_next;
          end
        end
        MEASURE: begin
          // A terminating rise beats the timeout when both land on the same cycle.
          if (rise) begin
            state_reg      <= DONE;
            period_reg     <= cnt_reg;
            meas_valid_reg <= 1'b1;
          end else if (at_limit) begin
            state_reg      <= DONE;
            timeout_reg    <= 1'b1;
            meas_valid_reg <= 1'b1;
            period_reg     <= '0;
            high_time_reg  <= '0;
          end else begin
            cnt_reg <= cnt_next;
            if (fall && !high_seen_reg) begin
              high_time_reg <= cnt_reg;
              high_seen_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          if (meas_ack) begin
            state_reg      <= IDLE;
            meas_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy       = (state_reg != IDLE);
  assign meas_valid = meas_valid_reg;
  assign period     = period_reg;
  assign high_time  = high_time_reg;
  assign timeout    = timeout_reg;

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter with TIMEOUT=100, COUNT_W=8.
module tb_clock_period_meter;

  logic       clk_27     = 1'b0;
  logic       reset      = 1'b1;
  logic       sig_in     = 1'b0;
  logic       start      = 1'b0;
  logic       meas_ack   = 1'b0;
  logic       busy;
  logic       meas_valid;
  logic       timeout;
  logic [7:0] period;
  logic [7:0] high_time;

  clock_period_meter #(
    .COUNT_W    (8),
    .TIMEOUT    (100),
    .SYNC_STAGES(2)
  ) dut (
    .clk_27    (clk_27),
    .reset     (reset),
    .sig_in    (sig_in),
    .start     (start),
    .busy      (busy),
    .meas_valid(meas_valid),
    .meas_ack  (meas_ack),
    .period    (period),
    .high_time (high_time),
    .timeout   (timeout)
  );

  // clk_27 period is 100 time units; the async wave uses 2037 units (20.37 cycles).
  always #50 clk_27 = ~clk_27;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string name;
    int    p_lo;
    int    p_hi;
    int    h_lo;
    int    h_hi;
    int    to;
  } exp_t;

  exp_t exp_q[$];

  // sig_in source: 0 = hold sig_hold, 1 = clk-aligned square wave, 2 = free-running async wave
  int   mode      = 0;
  int   last_mode = 0;
  int   sq_period = 20;
  int   sq_high   = 10;
  int   phase     = 0;
  logic sig_hold  = 1'b0;

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d want %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    check_range(name, got, want, want);
  endtask

  initial begin
    forever begin
      if (mode == 2) begin
        sig_in = 1'b0;
        #($urandom_range(0, 2036));
        while (mode == 2) begin
          sig_in = 1'b1;
          #1018;
          sig_in = 1'b0;
          #1019;
        end
        last_mode = 2;
      end else begin
        @(negedge clk_27);
        if (mode == 1) begin
          if (last_mode != 1) phase = 0;
          sig_in = (phase < sq_high);
          phase  = (phase + 1 == sq_period) ? 0 : phase + 1;
        end else begin
          sig_in = sig_hold;
        end
        last_mode = mode;
      end
    end
  end

  // Monitor: pops one expectation per result, then checks the result holds until it drops.
  exp_t       cur;
  bit         in_result = 1'b0;
  logic [7:0] hold_p;
  logic [7:0] hold_h;
  logic       hold_t;

  always @(negedge clk_27) begin
    if (reset || !meas_valid) begin
      in_result = 1'b0;
    end else if (!in_result) begin
      in_result = 1'b1;
      hold_p    = period;
      hold_h    = high_time;
      hold_t    = timeout;
      $display("result: period=%0d high_time=%0d timeout=%0d", period, high_time, timeout);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got period=%0d want no result", period);
      end else begin
        cur = exp_q.pop_front();
        check_range({cur.name, " period"}, int'(period), cur.p_lo, cur.p_hi);
        check_range({cur.name, " high_time"}, int'(high_time), cur.h_lo, cur.h_hi);
        check({cur.name, " timeout"}, int'(timeout), cur.to);
      end
    end else begin
      check("result_stable", int'({period, high_time, timeout}), int'({hold_p, hold_h, hold_t}));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_27);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_ack();
    meas_ack = 1'b1;
    tick(1);
    meas_ack = 1'b0;
  endtask

  task automatic push(input string name, input int plo, input int phi, input int hlo,
                      input int hhi, input int to);
    exp_t e;
    e.name = name; e.p_lo = plo; e.p_hi = phi; e.h_lo = hlo; e.h_hi = hhi; e.to = to;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input string name, input int max, output int n);
    n = 0;
    while (!meas_valid && n < max) begin
      tick(1);
      n++;
    end
    if (!meas_valid) begin
      checks++;
      errors++;
      $display("FAIL %s wait: got no meas_valid want meas_valid within %0d cycles", name, max);
    end
  endtask

  int n;

  initial begin
    tick(3);
    reset = 1'b0;
    tick(1);
    check("reset busy", int'(busy), 0);
    check("reset meas_valid", int'(meas_valid), 0);
    check("reset timeout", int'(timeout), 0);
    check("reset period", int'(period), 0);
    check("reset high_time", int'(high_time), 0);

    // Square wave 20/10, result held 5 cycles before ack.
    sq_period = 20; sq_high = 10; mode = 1;
    tick(25);
    push("sq20", 20, 20, 10, 10, 0);
    pulse_start();
    check("sq20 busy", int'(busy), 1);
    wait_valid("sq20", 100, n);
    tick(5);
    check("sq20 held valid", int'(meas_valid), 1);
    do_ack();
    check("sq20 busy after ack", int'(busy), 0);
    check("sq20 valid after ack", int'(meas_valid), 0);

    // Duty 3/17.
    mode = 0; tick(3);
    sq_period = 17; sq_high = 3; mode = 1;
    tick(20);
    push("duty3_17", 17, 17, 3, 3, 0);
    pulse_start();
    wait_valid("duty3_17", 100, n);
    do_ack();

    // Stuck low: timeout exactly 100 cycles after ARM entry.
    mode = 0; sig_hold = 1'b0; tick(5);
    push("stuck0", 0, 0, 0, 0, 1);
    pulse_start();
    wait_valid("stuck0", 300, n);
    check("stuck0 latency", n, 100);
    do_ack();

    // Stuck high: no rise ever seen after start.
    sig_hold = 1'b1; tick(10);
    push("stuck1", 0, 0, 0, 0, 1);
    pulse_start();
    wait_valid("stuck1", 300, n);
    check("stuck1 latency", n, 100);
    do_ack();

    // Starts in ARM and MEASURE ignored; start with ack in DONE does not restart.
    sig_hold = 1'b0; tick(5);
    push("busy_start", 20, 20, 10, 10, 0);
    pulse_start();
    pulse_start();
    sig_hold = 1'b1;
    tick(8);
    pulse_start();
    tick(1);
    sig_hold = 1'b0;
    tick(4);
    pulse_start();
    tick(5);
    sig_hold = 1'b1;
    wait_valid("busy_start", 50, n);
    start = 1'b1; meas_ack = 1'b1;
    tick(1);
    start = 1'b0; meas_ack = 1'b0;
    check("ack_start busy", int'(busy), 0);
    tick(5);
    check("ack_start no restart busy", int'(busy), 0);
    check("ack_start no restart valid", int'(meas_valid), 0);

    // Reset in the middle of MEASURE, then a fresh measurement.
    sig_hold = 1'b0; tick(3);
    pulse_start();
    sig_hold = 1'b1;
    tick(8);
    reset = 1'b1;
    tick(1);
    check("midreset busy", int'(busy), 0);
    check("midreset meas_valid", int'(meas_valid), 0);
    check("midreset period", int'(period), 0);
    reset = 1'b0; sig_hold = 1'b0;
    tick(3);
    sq_period = 20; sq_high = 10; mode = 1;
    tick(25);
    push("after_reset", 20, 20, 10, 10, 0);
    pulse_start();
    wait_valid("after_reset", 100, n);
    do_ack();

    // Asynchronous 20.37-cycle wave with random phase.
    mode = 0; tick(3);
    for (int run = 0; run < 200; run++) begin
      mode = 2;
      tick(1);
      push("async", 20, 21, 10, 11, 0);
      pulse_start();
      wait_valid("async", 100, n);
      do_ack();
      mode = 0;
      tick(25);
    end

    tick(3);
    check("queue drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
